// File: rtl/ltssm_detect.sv
// Detect-stage sequencer: Quiet dwell, PHY receiver-detect handshake, and a
// saturating count of detect attempts that found no receiver.
module ltssm_detect #(
    parameter int unsigned TIMEOUT_CYCLES = 2400000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       enable_i,
    input  logic       eidle_exit_i,
    output logic       rxdet_req_o,
    input  logic       rxdet_ack_i,
    input  logic       rxdet_present_i,
    output logic       detect_done_o,
    output logic [1:0] state_o,
    output logic [7:0] attempts_o
);

    // state     | meaning
    // IDLE      | sequence disabled, attempt count held
    // QUIET     | dwell before next receiver-detect attempt
    // ACTIVE    | receiver-detect request outstanding to the PHY
    // DETECTED  | receiver found, Polling may be entered
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_QUIET    = 2'd1,
        ST_ACTIVE   = 2'd2,
        ST_DETECTED = 2'd3
    } state_e;

    localparam logic [31:0] DWELL_LAST = TIMEOUT_CYCLES - 32'd1;

    state_e      state_q, state_d;
    logic [31:0] dwell_q, dwell_d;
    logic [7:0]  attempts_q, attempts_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            dwell_q    <= '0;
            attempts_q <= '0;
        end else begin
            state_q    <= state_d;
            dwell_q    <= dwell_d;
            attempts_q <= attempts_d;
        end
    end

    // The dwell counter only advances while QUIET is held, so it reads zero on
    // the first cycle of every QUIET visit and can never pass DWELL_LAST.
    always_comb begin
        state_d    = state_q;
        dwell_d    = '0;
        attempts_d = attempts_q;
        if (!enable_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d    = ST_QUIET;
                    attempts_d = '0;
                end
                ST_QUIET: begin
                    if (eidle_exit_i || (dwell_q == DWELL_LAST)) begin
                        state_d = ST_ACTIVE;
                    end else begin
                        dwell_d = dwell_q + 32'd1;
                    end
                end
                ST_ACTIVE: begin
                    if (rxdet_ack_i) begin
                        if (rxdet_present_i) begin
                            state_d = ST_DETECTED;
                        end else begin
                            state_d = ST_QUIET;
                            if (attempts_q != 8'hFF) begin
                                attempts_d = attempts_q + 8'd1;
                            end
                        end
                    end
                end
                ST_DETECTED: state_d = ST_DETECTED;
                default:     state_d = ST_IDLE;
            endcase
        end
    end

    assign rxdet_req_o   = (state_q == ST_ACTIVE);
    assign detect_done_o = (state_q == ST_DETECTED);
    assign state_o       = state_q;
    assign attempts_o    = attempts_q;

endmodule

// File: doc/ltssm_detect.md
LTSSM_DETECT -- requirements
Module: ltssm_detect

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 2400000, Detect.Quiet dwell in clk_i cycles (12 ms at 200 MHz); legal range 2..2^32-1.
REQ-002 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port enable_i  input  1  level; high requests the Detect sequence, low aborts it.
REQ-005 SHALL have port eidle_exit_i  input  1  level; electrical-idle exit seen on any lane.
REQ-006 SHALL have port rxdet_req_o  output  1  receiver-detect request to the PHY.
REQ-007 SHALL have port rxdet_ack_i  input  1  single-cycle PHY completion strobe.
REQ-008 SHALL have port rxdet_present_i  input  1  detect result; valid only while rxdet_ack_i is high.
REQ-009 SHALL have port detect_done_o  output  1  receiver found; Polling may be entered.
REQ-010 SHALL have port state_o  output  2  current state (IDLE=0, QUIET=1, ACTIVE=2, DETECTED=3).
REQ-011 SHALL have port attempts_o  output  8  saturating count of detect attempts that found no receiver.

Function
REQ-012 SHALL implement a 4-state FSM: IDLE, QUIET, ACTIVE, DETECTED; state_o is the registered state.
REQ-013 IDLE: if enable_i=1, next state SHALL be QUIET, and attempts_o SHALL clear to 0 on that transition.
REQ-014 QUIET: a 32-bit dwell counter SHALL be 0 on the first QUIET cycle and increment by 1 each QUIET cycle.
REQ-015 QUIET: when counter == TIMEOUT_CYCLES-1, next state SHALL be ACTIVE, so QUIET lasts exactly TIMEOUT_CYCLES cycles.
REQ-016 QUIET: eidle_exit_i=1 SHALL force next state ACTIVE regardless of counter value.
REQ-017 The dwell counter SHALL clear to 0 in every non-QUIET state and SHALL NOT wrap.
REQ-018 ACTIVE: rxdet_req_o SHALL be 1 from the first ACTIVE cycle until the cycle rxdet_ack_i is sampled 1, inclusive.
REQ-019 rxdet_req_o SHALL be 0 in all other states, including the cycle after ack.
REQ-020 ACTIVE with rxdet_ack_i=1 and rxdet_present_i=1: next state SHALL be DETECTED.
REQ-021 ACTIVE with rxdet_ack_i=1 and rxdet_present_i=0: next state SHALL be QUIET, and attempts_o SHALL increment, saturating at 255.
REQ-022 rxdet_ack_i and rxdet_present_i SHALL be ignored outside ACTIVE.
REQ-023 DETECTED: detect_done_o SHALL be 1; it SHALL be 0 in all other states. State SHALL hold while enable_i=1.
REQ-024 enable_i=0 in any state SHALL force next state IDLE, with priority over timeout, eidle_exit_i and ack.
REQ-025 An abort from ACTIVE SHALL drop rxdet_req_o on the next cycle; a late ack SHALL then be ignored.
REQ-026 attempts_o SHALL hold its value in IDLE until the next IDLE->QUIET transition.

Reset
REQ-027 While rst_ni=0: state SHALL be IDLE, dwell counter 0, attempts_o 0, rxdet_req_o 0, detect_done_o 0, state_o 0.
REQ-028 Reset assertion mid-sequence SHALL take effect immediately (asynchronously); deassertion SHALL be synchronous to clk_i.
REQ-029 The first state evaluation after reset release SHALL be from IDLE.

Verification (TIMEOUT_CYCLES=16)
REQ-030 The bench SHALL check: enable_i 1 at cycle 0 -> QUIET cycles 1..16, state_o=2 and rxdet_req_o=1 at cycle 17.
REQ-031 The bench SHALL check: in ACTIVE, ack=1 with present=1 -> next cycle state_o=3, detect_done_o=1, rxdet_req_o=0, attempts_o=0.
REQ-032 The bench SHALL check: three absent acks -> attempts_o=3, each followed by a full 16-cycle QUIET; force 300 absent acks -> attempts_o=255.
REQ-033 The bench SHALL check: eidle_exit_i=1 on the 3rd QUIET cycle -> state_o=2 next cycle, with the counter reset.
REQ-034 The bench SHALL check: enable_i=0 in ACTIVE, ack one cycle later -> state_o=0, rxdet_req_o=0, attempts_o unchanged.
REQ-035 The bench SHALL check: rst_ni=0 in DETECTED -> all outputs 0 without a clock edge; re-enable -> full 16-cycle QUIET.
